// File: rtl/iobus_pkg.sv
// Shared IOBUS definitions: arbiter state encoding and peripheral port addresses.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package iobus_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [31:0] LEDS_AD     = 32'h1100_C000;
  localparam logic [31:0] SSEG_AD     = 32'h1100_C004;
  localparam logic [31:0] ANODES_AD   = 32'h1100_C008;
  localparam logic [31:0] SWITCHES_AD = 32'h1100_0004;
  localparam logic [31:0] BUTTONS_AD  = 32'h1100_8004;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: one-hot winner from two requests and last-granted index.
// Latency: purely combinational.
// Backpressure: none; a zero request vector yields a zero winner.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // On a tie the requester that was not granted last wins; otherwise the lone requester.
  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/iobus_arbiter.sv
// Two-requester IOBUS arbiter with round-robin fairness and an ownership lock.
// Latency: req sampled cycle N -> gnt/bus access N+1 -> rvalid N+2; one transaction per 2 cycles.
// Backpressure: requesters hold their command until gnt; a locked owner blocks the other requester.
module iobus_arbiter
  import iobus_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  output logic          rvalid0,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic          rvalid1,
  output logic [AW-1:0] IOBUS_ADDR,
  output logic [DW-1:0] IOBUS_OUT,
  output logic          IOBUS_WR,
  input  logic [DW-1:0] IOBUS_IN
);

  state_t        state;
  logic          owner;      // 0 = requester 0 holds the current/last transaction
  logic          last;       // index of the requester granted most recently
  logic          locked;
  logic          lat_wr;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic          in_access;
  logic          owner_lock;
  logic          lock_hold;
  logic [1:0]    reqs;
  logic [1:0]    elig;
  logic [1:0]    win;

  assign in_access  = (state == ACCESS);
  assign owner_lock = owner ? lock1 : lock0;
  // A lock the owner has just released no longer restricts arbitration in this cycle.
  assign lock_hold  = locked & owner_lock;
  assign reqs       = {req1, req0};
  assign elig       = lock_hold ? (reqs & (owner ? 2'b10 : 2'b01)) : reqs;

  rr_pick2 u_pick (
    .req  (elig),
    .last (last),
    .win  (win)
  );

  // Bus and grant outputs decode straight from state so a reset drops them at once.
  assign IOBUS_ADDR = in_access ? lat_addr  : '0;
  assign IOBUS_OUT  = in_access ? lat_wdata : '0;
  assign IOBUS_WR   = in_access & lat_wr;
  assign gnt0       = in_access & ~owner;
  assign gnt1       = in_access &  owner;

  // Arbitration FSM: latch the winner's command in IDLE, spend exactly one cycle in ACCESS.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      locked    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (locked && !owner_lock) begin
            locked <= 1'b0;
          end
          if (win != 2'b00) begin
            state     <= ACCESS;
            owner     <= win[1];
            last      <= win[1];
            lat_wr    <= win[1] ? wr1    : wr0;
            lat_addr  <= win[1] ? addr1  : addr0;
            lat_wdata <= win[1] ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          state <= IDLE;
          if (owner_lock) begin
            locked <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read return: capture bus data for the owner when a read access ends, pulse rvalid once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= in_access & ~lat_wr & ~owner;
      rvalid1 <= in_access & ~lat_wr &  owner;
      if (in_access && !lat_wr && !owner) begin
        rdata0 <= IOBUS_IN;
      end
      if (in_access && !lat_wr && owner) begin
        rdata1 <= IOBUS_IN;
      end
    end
  end

endmodule

// File: tb/tb_iobus_arbiter.sv
// Directed bench for iobus_arbiter: reset, single read/write, contention, lock, reset abort.
// Latency: checks gnt one cycle and rvalid two cycles after a request is sampled.
// Backpressure: exercises lock-induced waiting of the non-owner requester.
module tb_iobus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK;
  logic          RESET;
  logic          req0, wr0, lock0, req1, wr1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] IOBUS_ADDR;
  logic [DW-1:0] IOBUS_OUT;
  logic          IOBUS_WR;
  logic [DW-1:0] IOBUS_IN;

  int n_checks = 0;
  int n_errors = 0;

  iobus_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req0       (req0),
    .wr0        (wr0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .lock0      (lock0),
    .req1       (req1),
    .wr1        (wr1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .lock1      (lock1),
    .gnt0       (gnt0),
    .rdata0     (rdata0),
    .rvalid0    (rvalid0),
    .gnt1       (gnt1),
    .rdata1     (rdata1),
    .rvalid1    (rvalid1),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0; lock0 = 1'b0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0; lock1 = 1'b0;
  endtask

  task automatic reset_and_check(input string tag);
    RESET = 1'b1;
    #1;
    check({tag, "_wr"},     IOBUS_WR,   0);
    check({tag, "_addr"},   IOBUS_ADDR, 0);
    check({tag, "_out"},    IOBUS_OUT,  0);
    check({tag, "_gnt0"},   gnt0,       0);
    check({tag, "_gnt1"},   gnt1,       0);
    check({tag, "_rvld0"},  rvalid0,    0);
    check({tag, "_rvld1"},  rvalid1,    0);
    check({tag, "_rdata0"}, rdata0,     0);
    check({tag, "_rdata1"}, rdata1,     0);
    tick;
    RESET = 1'b0;
  endtask

  logic [31:0] a0, a1;
  logic        exp_own;

  initial begin
    idle_inputs();
    IOBUS_IN = '0;
    RESET    = 1'b0;
    #2;
    reset_and_check("rst0");

    // Single read by requester 0
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h1100_0004;
    IOBUS_IN = 32'h0000_A5A5;
    tick;
    check("rd_gnt0", gnt0, 1);
    check("rd_gnt1", gnt1, 0);
    check("rd_addr", IOBUS_ADDR, 32'h1100_0004);
    check("rd_wr",   IOBUS_WR, 0);
    req0 = 1'b0; addr0 = 32'hDEAD_0000;
    #1;
    check("rd_addr_held", IOBUS_ADDR, 32'h1100_0004);
    tick;
    check("rd_rvld0",  rvalid0, 1);
    check("rd_rdata0", rdata0, 32'h0000_A5A5);
    check("rd_gnt_off", gnt0, 0);
    check("rd_addr_off", IOBUS_ADDR, 0);
    tick;
    check("rd_rvld0_pulse", rvalid0, 0);
    check("rd_rdata0_hold", rdata0, 32'h0000_A5A5);

    // Single write by requester 1
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h1100_C000; wdata1 = 32'h0000_1234;
    tick;
    check("wr_gnt1", gnt1, 1);
    check("wr_gnt0", gnt0, 0);
    check("wr_wr",   IOBUS_WR, 1);
    check("wr_out",  IOBUS_OUT, 32'h0000_1234);
    check("wr_addr", IOBUS_ADDR, 32'h1100_C000);
    req1 = 1'b0;
    tick;
    check("wr_rvld1",  rvalid1, 0);
    check("wr_wr_off", IOBUS_WR, 0);
    check("wr_rdata1", rdata1, 0);
    check("wr_rdata0_keep", rdata0, 32'h0000_A5A5);

    // Reset clears read data held from before
    idle_inputs();
    reset_and_check("rst1");

    // Contention: both requesters read continuously, 8 transactions
    a0 = 32'h1100_0004; a1 = 32'h1100_8004;
    req0 = 1'b1; wr0 = 1'b0; addr0 = a0;
    req1 = 1'b1; wr1 = 1'b0; addr1 = a1;
    IOBUS_IN = 32'h0000_0B0B;
    exp_own = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick;
      check("ct_both_gnt", gnt0 & gnt1, 0);
      if (t % 2 == 0) begin
        check("ct_gnt0", gnt0, !exp_own);
        check("ct_gnt1", gnt1, exp_own);
        check("ct_addr", IOBUS_ADDR, exp_own ? a1 : a0);
        if (exp_own) begin a1 = a1 + 32'h100; addr1 = a1; end
        else         begin a0 = a0 + 32'h100; addr0 = a0; end
        if (t == 14) begin req0 = 1'b0; req1 = 1'b0; end
      end else begin
        check("ct_idle_gnt", gnt0 | gnt1, 0);
        check("ct_rvld", exp_own ? rvalid1 : rvalid0, 1);
        check("ct_both_rvld", rvalid0 & rvalid1, 0);
        exp_own = ~exp_own;
      end
    end
    tick;
    check("ct_done", gnt0 | gnt1, 0);

    // Lock: requester 0 keeps ownership for three transactions
    idle_inputs();
    reset_and_check("rst2");
    req0 = 1'b1; lock0 = 1'b1; wr0 = 1'b1; addr0 = 32'h1100_C008; wdata0 = 32'h1;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h1100_C000; wdata1 = 32'h2;
    tick;
    check("lk_gnt0_a", gnt0, 1);
    req0 = 1'b0;
    tick;
    tick;
    check("lk_wait_a", gnt1, 0);
    tick;
    check("lk_wait_b", gnt1, 0);
    req0 = 1'b1; wdata0 = 32'h3;
    tick;
    check("lk_gnt0_b", gnt0, 1);
    tick;
    check("lk_gap", gnt0 | gnt1, 0);
    tick;
    check("lk_gnt0_c", gnt0, 1);
    lock0 = 1'b0;
    tick;
    tick;
    check("lk_rel_gnt1", gnt1, 1);
    check("lk_rel_gnt0", gnt0, 0);

    // Reset during a write access by requester 0
    idle_inputs();
    tick;
    reset_and_check("rst3");
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h1100_C004; wdata0 = 32'h55;
    tick;
    check("ra_wr_on", IOBUS_WR, 1);
    check("ra_gnt0",  gnt0, 1);
    #2;
    RESET = 1'b1;
    #1;
    check("ra_wr_drop",   IOBUS_WR, 0);
    check("ra_gnt_drop",  gnt0, 0);
    check("ra_addr_drop", IOBUS_ADDR, 0);
    tick;
    check("ra_no_rvld", rvalid0 | rvalid1, 0);
    check("ra_no_gnt",  gnt0 | gnt1, 0);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h1100_0004;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h1100_8004;
    RESET = 1'b0;
    tick;
    check("ra_first_gnt0", gnt0, 1);
    check("ra_first_gnt1", gnt1, 0);
    idle_inputs();
    tick;
    tick;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
